// File: rtl/xdn_defs.sv
// Shared definitions for the register file: default sizes, select-width helper,
// named register indices and the in-place modify operation encoding.
package xdn_defs;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_NUM_REGS   = 4;

    typedef enum logic [1:0] {
        REG_A = 2'd0,
        REG_B = 2'd1,
        REG_C = 2'd2,
        REG_D = 2'd3
    } reg_idx_e;

    typedef enum logic [1:0] {
        MOD_NONE = 2'd0,
        MOD_INC  = 2'd1,
        MOD_DEC  = 2'd2
    } mod_op_e;

    // Width of a register select; never narrower than one bit.
    function automatic int reg_sel_w(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/register_cell.sv
// One register of the file: async clear, bus load, and in-place increment/decrement.
// A bus load takes priority over any modify requested in the same cycle.
module register_cell
    import xdn_defs::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  i_CLOCK,
    input  logic                  i_CLEAR,
    input  logic                  load,
    input  mod_op_e               mod_op,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] value
);

    logic [DATA_WIDTH-1:0] value_r;

    // Register state: clear, then load, then modify, otherwise hold.
    always_ff @(posedge i_CLOCK or posedge i_CLEAR) begin
        if (i_CLEAR) begin
            value_r <= '0;
        end else if (load) begin
            value_r <= load_data;
        end else begin
            case (mod_op)
                MOD_INC: value_r <= value_r + DATA_WIDTH'(1);
                MOD_DEC: value_r <= value_r - DATA_WIDTH'(1);
                default: value_r <= value_r;
            endcase
        end
    end

    assign value = value_r;

endmodule

// File: rtl/register_file.sv
// Bank of NUM_REGS CPU registers on a shared tristate bus with two ALU read ports.
// Optional registered wrap/borrow flag o_CARRY when REGFILE_CARRY_EN is defined.
module register_file
    import xdn_defs::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int NUM_REGS   = DEFAULT_NUM_REGS,
    localparam int ADDR_W     = reg_sel_w(NUM_REGS)
) (
    input  logic                  i_CLOCK,
    input  logic                  i_CLEAR,
    inout  wire  [DATA_WIDTH-1:0] BUS,
    input  logic                  i_READ_BUS_n,
    input  logic [ADDR_W-1:0]     i_LOAD_SEL,
    input  logic                  i_WRITE_BUS_n,
    input  logic [ADDR_W-1:0]     i_DRIVE_SEL,
    input  logic                  i_INC_n,
    input  logic                  i_DEC_n,
    input  logic [ADDR_W-1:0]     i_MOD_SEL,
    input  logic [ADDR_W-1:0]     i_A_SEL,
    input  logic [ADDR_W-1:0]     i_B_SEL,
    output logic [DATA_WIDTH-1:0] o_A_DATA,
    output logic [DATA_WIDTH-1:0] o_B_DATA
`ifdef REGFILE_CARRY_EN
   ,output logic                  o_CARRY
`endif
);

    localparam logic [ADDR_W:0] SEL_LIMIT = (ADDR_W + 1)'(NUM_REGS);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_s;
    logic [NUM_REGS-1:0]                 load_s;
    mod_op_e                             op_s;
    mod_op_e                             cell_op_s [NUM_REGS];

    // Out-of-range selects read as zero so non-power-of-2 banks stay well defined.
    function automatic logic [DATA_WIDTH-1:0] read_sel(
        input logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs,
        input logic [ADDR_W-1:0]                   sel
    );
        if ({1'b0, sel} < SEL_LIMIT) begin
            return regs[sel];
        end else begin
            return '0;
        end
    endfunction

    // Inc and dec requested together cancel each other.
    always_comb begin
        op_s = MOD_NONE;
        if (!i_INC_n && i_DEC_n) begin
            op_s = MOD_INC;
        end else if (i_INC_n && !i_DEC_n) begin
            op_s = MOD_DEC;
        end else begin
            op_s = MOD_NONE;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
        assign load_s[g]    = !i_READ_BUS_n && (i_LOAD_SEL == ADDR_W'(g));
        assign cell_op_s[g] = (i_MOD_SEL == ADDR_W'(g)) ? op_s : MOD_NONE;

        register_cell #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_cell (
            .i_CLOCK  (i_CLOCK),
            .i_CLEAR  (i_CLEAR),
            .load     (load_s[g]),
            .mod_op   (cell_op_s[g]),
            .load_data(BUS),
            .value    (regs_s[g])
        );
    end

    assign o_A_DATA = read_sel(regs_s, i_A_SEL);
    assign o_B_DATA = read_sel(regs_s, i_B_SEL);
    assign BUS      = i_WRITE_BUS_n ? {DATA_WIDTH{1'bz}} : read_sel(regs_s, i_DRIVE_SEL);

`ifdef REGFILE_CARRY_EN
    logic                  carry_r;
    logic                  mod_valid_s;
    logic                  mod_accept_s;
    logic                  mod_wrap_s;
    logic [DATA_WIDTH-1:0] mod_val_s;

    // A modify only counts when it targets a real register not being bus-loaded.
    assign mod_valid_s  = {1'b0, i_MOD_SEL} < SEL_LIMIT;
    assign mod_accept_s = (op_s != MOD_NONE) && mod_valid_s &&
                          !(!i_READ_BUS_n && (i_LOAD_SEL == i_MOD_SEL));
    assign mod_val_s    = read_sel(regs_s, i_MOD_SEL);
    assign mod_wrap_s   = (op_s == MOD_INC) ? (mod_val_s == {DATA_WIDTH{1'b1}})
                                            : (mod_val_s == {DATA_WIDTH{1'b0}});

    // Carry flag: updated by each accepted inc/dec, held otherwise.
    always_ff @(posedge i_CLOCK or posedge i_CLEAR) begin
        if (i_CLEAR) begin
            carry_r <= 1'b0;
        end else if (mod_accept_s) begin
            carry_r <= mod_wrap_s;
        end else begin
            carry_r <= carry_r;
        end
    end

    assign o_CARRY = carry_r;
`endif

endmodule

// File: tb/tb_register_file.sv
// Randomized bench for register_file: a 4-register and a 3-register instance share
// control inputs and are compared against array-based models of the register bank.
module tb_register_file;
    import xdn_defs::*;

    logic       clk = 1'b0;
    logic       clr, read_n, write_n, inc_n, dec_n, tb_drv;
    logic [1:0] load_sel, drive_sel, mod_sel, a_sel, b_sel;
    logic [7:0] tb_val;
    wire  [7:0] bus4, bus3;
    logic [7:0] a4, b4, a3, b3;
`ifdef REGFILE_CARRY_EN
    logic       c4_o, c3_o;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:0] m4 [4];
    logic [7:0] m3 [3];
    logic       mc4, mc3;

    initial forever #5 clk = ~clk;

    assign bus4 = tb_drv ? tb_val : 8'hzz;
    assign bus3 = tb_drv ? tb_val : 8'hzz;

    register_file dut4 (
        .i_CLOCK(clk), .i_CLEAR(clr), .BUS(bus4),
        .i_READ_BUS_n(read_n), .i_LOAD_SEL(load_sel),
        .i_WRITE_BUS_n(write_n), .i_DRIVE_SEL(drive_sel),
        .i_INC_n(inc_n), .i_DEC_n(dec_n), .i_MOD_SEL(mod_sel),
        .i_A_SEL(a_sel), .i_B_SEL(b_sel),
        .o_A_DATA(a4), .o_B_DATA(b4)
`ifdef REGFILE_CARRY_EN
       ,.o_CARRY(c4_o)
`endif
    );

    register_file #(.NUM_REGS(3)) dut3 (
        .i_CLOCK(clk), .i_CLEAR(clr), .BUS(bus3),
        .i_READ_BUS_n(read_n), .i_LOAD_SEL(load_sel),
        .i_WRITE_BUS_n(write_n), .i_DRIVE_SEL(drive_sel),
        .i_INC_n(inc_n), .i_DEC_n(dec_n), .i_MOD_SEL(mod_sel),
        .i_A_SEL(a_sel), .i_B_SEL(b_sel),
        .o_A_DATA(a3), .o_B_DATA(b3)
`ifdef REGFILE_CARRY_EN
       ,.o_CARRY(c3_o)
`endif
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rd3(input logic [1:0] s);
        if (s == 2'd3) return 8'h00;
        else return m3[s];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m4[i] = 8'h00;
        for (int i = 0; i < 3; i++) m3[i] = 8'h00;
        mc4 = 1'b0;
        mc3 = 1'b0;
    endtask

    // Bank semantics: exactly one of inc/dec applies unless the target is bus-loaded.
    task automatic model_update(input logic rn, input logic [1:0] ls, input logic [7:0] v4,
                                input logic [7:0] v3, input logic iv, input logic dv,
                                input logic [1:0] ms);
        logic       up, down, hit;
        logic [7:0] old;
        up   = !iv && dv;
        down = iv && !dv;
        hit  = !rn && (ls == ms);
        if ((up || down) && !hit) begin
            old     = m4[ms];
            m4[ms]  = up ? old + 8'd1 : old - 8'd1;
            mc4     = up ? (old == 8'hFF) : (old == 8'h00);
            if (ms != 2'd3) begin
                old    = m3[ms];
                m3[ms] = up ? old + 8'd1 : old - 8'd1;
                mc3    = up ? (old == 8'hFF) : (old == 8'h00);
            end
        end
        if (!rn) begin
            m4[ls] = v4;
            if (ls != 2'd3) m3[ls] = v3;
        end
    endtask

    // One clock cycle: apply at negedge, check combinational outputs, update model at posedge.
    task automatic step(input logic rn, input logic [1:0] ls, input logic wn, input logic [1:0] ds,
                        input logic iv, input logic dv, input logic [1:0] ms, input logic [7:0] v,
                        input logic [1:0] as, input logic [1:0] bs);
        logic [7:0] v4, v3;
        read_n = rn; load_sel = ls; write_n = wn; drive_sel = ds;
        inc_n = iv; dec_n = dv; mod_sel = ms; a_sel = as; b_sel = bs;
        tb_drv = wn; tb_val = v;
        #1;
        check_eq("rdA4", a4, m4[as]);
        check_eq("rdB4", b4, m4[bs]);
        check_eq("rdA3", a3, rd3(as));
        check_eq("rdB3", b3, rd3(bs));
`ifdef REGFILE_CARRY_EN
        check_eq("carry4", {7'd0, c4_o}, {7'd0, mc4});
        check_eq("carry3", {7'd0, c3_o}, {7'd0, mc3});
`endif
        if (!wn) begin
            check_eq("bus4", bus4, m4[ds]);
            check_eq("bus3", bus3, rd3(ds));
        end
        v4 = wn ? v : m4[ds];
        v3 = wn ? v : rd3(ds);
        @(posedge clk);
        model_update(rn, ls, v4, v3, iv, dv, ms);
        @(negedge clk);
    endtask

    task automatic load(input logic [1:0] sel, input logic [7:0] v);
        step(1'b0, sel, 1'b1, 2'd0, 1'b1, 1'b1, 2'd0, v, 2'd0, 2'd1);
    endtask

    task automatic peek_a(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        a_sel = sel;
        #1;
        check_eq(tag, a4, exp);
    endtask

    initial begin
        clr = 1'b1; read_n = 1'b1; write_n = 1'b1; inc_n = 1'b1; dec_n = 1'b1;
        load_sel = 2'd0; drive_sel = 2'd0; mod_sel = 2'd0; a_sel = 2'd0; b_sel = 2'd1;
        tb_drv = 1'b0; tb_val = 8'h00;
        model_clear();
        #2;
        check_eq("rst_a4", a4, 8'h00);
        check_eq("rst_b4", b4, 8'h00);
        check_eq("rst_a3", a3, 8'h00);
        @(negedge clk);
        clr = 1'b0;

        // Load, then drive the same register straight back out.
        load(2'd2, 8'h5A);
        peek_a("load_5a", 2'd2, 8'h5A);
        tb_drv = 1'b0; write_n = 1'b0; drive_sel = 2'd2;
        #1;
        check_eq("drive_5a", bus4, 8'h5A);
        write_n = 1'b1;
        load(2'd0, 8'hC3);
        peek_a("release", 2'd0, 8'hC3);

        // Register-to-register move in one cycle.
        load(2'd1, 8'h33);
        step(1'b0, 2'd3, 1'b0, 2'd1, 1'b1, 1'b1, 2'd0, 8'h00, 2'd0, 2'd0);
        peek_a("move_dst", 2'd3, 8'h33);
        peek_a("move_src", 2'd1, 8'h33);
        step(1'b0, 2'd1, 1'b0, 2'd1, 1'b1, 1'b1, 2'd0, 8'h00, 2'd1, 2'd1);
        peek_a("self_move", 2'd1, 8'h33);

        // Wrap and borrow on reg0.
        load(2'd0, 8'hFF);
        step(1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, 8'h00, 2'd0, 2'd0);
        peek_a("inc_wrap", 2'd0, 8'h00);
`ifdef REGFILE_CARRY_EN
        check_eq("inc_carry", {7'd0, c4_o}, 8'h01);
`endif
        step(1'b1, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 2'd0);
        peek_a("dec_borrow", 2'd0, 8'hFF);
        step(1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, 8'h00, 2'd0, 2'd0);
        peek_a("inc_wrap2", 2'd0, 8'h00);
        load(2'd0, 8'h05);
        step(1'b1, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 2'd0);
        peek_a("dec_plain", 2'd0, 8'h04);
`ifdef REGFILE_CARRY_EN
        check_eq("dec_nocarry", {7'd0, c4_o}, 8'h00);
`endif

        // Conflicts: load beats inc; inc+dec cancel.
        step(1'b0, 2'd2, 1'b1, 2'd0, 1'b0, 1'b1, 2'd2, 8'h10, 2'd2, 2'd2);
        peek_a("load_wins", 2'd2, 8'h10);
        load(2'd1, 8'h07);
        step(1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd1, 8'h00, 2'd1, 2'd1);
        peek_a("inc_dec_cancel", 2'd1, 8'h07);

        // Out-of-range select on the 3-register instance.
        step(1'b0, 2'd3, 1'b1, 2'd0, 1'b0, 1'b1, 2'd3, 8'hAA, 2'd3, 2'd0);
        a_sel = 2'd3;
        #1;
        check_eq("sel3_a3", a3, 8'h00);

        // Clear held across an edge beats a pending load and inc.
        clr = 1'b1; read_n = 1'b0; load_sel = 2'd1; tb_drv = 1'b1; tb_val = 8'h77;
        inc_n = 1'b0; mod_sel = 2'd2; write_n = 1'b1;
        @(posedge clk);
        #1;
        a_sel = 2'd1; b_sel = 2'd2;
        #1;
        check_eq("clr_load", a4, 8'h00);
        check_eq("clr_inc", b4, 8'h00);
        @(negedge clk);
        clr = 1'b0;
        model_clear();

        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                clr = 1'b1;
                a_sel = 2'd3; b_sel = 2'd0;
                #1;
                check_eq("pulse_a4", a4, 8'h00);
                check_eq("pulse_b3", b3, 8'h00);
                #1;
                clr = 1'b0;
                model_clear();
            end
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
